rst_seq_ctrl: RTL and testbench

Reset sequencer downstream of the reset synchronizer. It consumes the already-synchronized active-low reset and releases NUM_OUTS per-domain resets one at a time, in ascending index order, with a programmable gap between releases. It also accepts a soft-reset request once the sequence is complete: it re-asserts all domain resets, holds them, then replays the release sequence. Downstream blocks see a thermometer-coded, glitch-free reset bus and a single "system ready" flag.

---
 rtl/rst_seq_ctrl.sv | 127 ++++++++++++
 tb/tb_rst_seq_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: releases NUM_OUTS domain resets one at a time after a
// programmable gap, and replays the sequence after an accepted soft request.
module rst_seq_ctrl #(
    parameter int unsigned NUM_OUTS  = 3,
    parameter int unsigned DLY_CYC   = 16,
    parameter int unsigned SOFT_HOLD = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                SOFT_RST_REQ,
    output logic [NUM_OUTS-1:0] SEQ_RST_N,
    output logic                RST_DONE,
    output logic                SOFT_ACK
);

    localparam int unsigned MAX_CYC = (DLY_CYC > SOFT_HOLD) ? DLY_CYC : SOFT_HOLD;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;
    localparam int unsigned IDX_W   = $clog2(NUM_OUTS + 1);

    localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(DLY_CYC - 1);
    localparam logic [CNT_W-1:0] SOFT_LAST = CNT_W'(SOFT_HOLD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_OUTS - 1);

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_DONE = 2'd1,
        ST_SOFT = 2'd2
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [NUM_OUTS-1:0] r_seq_rst_n;
    logic                r_rst_done;
    logic                r_soft_ack;

    state_t              w_state_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic [NUM_OUTS-1:0] w_seq_nxt;
    logic                w_done_nxt;
    logic                w_ack_nxt;
    logic [NUM_OUTS-1:0] w_rel_mask;

    // One-hot mask of the domain released next
    always_comb begin
        w_rel_mask = '0;
        for (int k = 0; k < int'(NUM_OUTS); k++) begin
            w_rel_mask[k] = (r_idx == IDX_W'(k));
        end
    end

    // State and output registers; RST overrides every other event
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state     <= ST_HOLD;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_seq_rst_n <= '0;
            r_rst_done  <= 1'b0;
            r_soft_ack  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_seq_rst_n <= w_seq_nxt;
            r_rst_done  <= w_done_nxt;
            r_soft_ack  <= w_ack_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_seq_nxt   = r_seq_rst_n;
        w_done_nxt  = r_rst_done;
        w_ack_nxt   = 1'b0;

        case (r_state)
            ST_HOLD: begin
                if (r_cnt == DLY_LAST) begin
                    w_cnt_nxt = '0;
                    w_idx_nxt = r_idx + IDX_W'(1);
                    w_seq_nxt = r_seq_rst_n | w_rel_mask;
                    if (r_idx == IDX_LAST) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_DONE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (SOFT_RST_REQ) begin
                    w_seq_nxt   = '0;
                    w_done_nxt  = 1'b0;
                    w_ack_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_SOFT;
                end
            end
            ST_SOFT: begin
                if (r_cnt == SOFT_LAST) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_HOLD;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
                w_seq_nxt   = '0;
                w_done_nxt  = 1'b0;
            end
        endcase
    end

    assign SEQ_RST_N = r_seq_rst_n;
    assign RST_DONE  = r_rst_done;
    assign SOFT_ACK  = r_soft_ack;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: two instances (nominal and minimum timing)
// share stimulus and are checked every edge against a timeline-based model.
module tb_rst_seq_ctrl;

    localparam int N     = 3;
    localparam int A_DLY = 4;
    localparam int A_SH  = 3;
    localparam int B_DLY = 1;
    localparam int B_SH  = 1;

    typedef struct {
        int origin;   // edge of the last reset-exit point
        int soft_s;   // edge a soft request was accepted, -1 when not holding
        bit done;
    } mdl_t;

    typedef struct {
        logic [N-1:0] seq;
        logic         done;
        logic         ack;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         req;
    logic [N-1:0] seq_a, seq_b;
    logic         done_a, done_b, ack_a, ack_b;

    int   n_checks = 0;
    int   n_errors = 0;
    int   edge_no  = 0;
    exp_t qa[$];
    exp_t qb[$];
    mdl_t ma, mb;

    rst_seq_ctrl #(.NUM_OUTS(N), .DLY_CYC(A_DLY), .SOFT_HOLD(A_SH)) u_dut_a (
        .CLK(clk), .RST(rst), .SOFT_RST_REQ(req),
        .SEQ_RST_N(seq_a), .RST_DONE(done_a), .SOFT_ACK(ack_a)
    );

    rst_seq_ctrl #(.NUM_OUTS(N), .DLY_CYC(B_DLY), .SOFT_HOLD(B_SH)) u_dut_b (
        .CLK(clk), .RST(rst), .SOFT_RST_REQ(req),
        .SEQ_RST_N(seq_b), .RST_DONE(done_b), .SOFT_ACK(ack_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected outputs after edge e, derived from the release timeline
    function automatic exp_t mstep(input int dly, input int sh, input int e,
                                   input bit rst_n, input bit rq,
                                   input mdl_t mi, output mdl_t mo);
        exp_t x;
        int   rel;
        mo     = mi;
        x.seq  = '0;
        x.done = 1'b0;
        x.ack  = 1'b0;
        if (!rst_n) begin
            mo.origin = e;
            mo.soft_s = -1;
            mo.done   = 1'b0;
            return x;
        end
        if (mi.done) begin
            if (rq) begin
                mo.soft_s = e;
                mo.done   = 1'b0;
                x.ack     = 1'b1;
            end else begin
                x.seq  = '1;
                x.done = 1'b1;
            end
            return x;
        end
        if (mi.soft_s >= 0) begin
            if (e - mi.soft_s < sh) return x;
            mo.origin = e;
            mo.soft_s = -1;
        end
        rel = (e - mo.origin) / dly;
        if (rel > N) rel = N;
        for (int k = 0; k < N; k++) x.seq[k] = (k < rel);
        if (rel == N) begin
            x.done  = 1'b1;
            mo.done = 1'b1;
        end
        return x;
    endfunction

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s edge %0d: got %b expected %b", name, edge_no, act, exp);
        end
    endtask

    // Sets inputs for the next edge and queues the model's response to it
    task automatic cyc(input bit r, input bit q);
        mdl_t nx;
        rst = r;
        req = q;
        qa.push_back(mstep(A_DLY, A_SH, edge_no + 1, r, q, ma, nx));
        ma = nx;
        qb.push_back(mstep(B_DLY, B_SH, edge_no + 1, r, q, mb, nx));
        mb = nx;
        @(posedge clk);
        #2;
    endtask

    // Monitor: compare each registered output set just after the edge
    always @(posedge clk) begin
        exp_t ea, eb;
        #1;
        edge_no++;
        if (qa.size() > 0) begin
            ea = qa.pop_front();
            chk("a_seq_rst_n", seq_a, ea.seq);
            chk("a_rst_done", N'(done_a), N'(ea.done));
            chk("a_soft_ack", N'(ack_a), N'(ea.ack));
        end
        if (qb.size() > 0) begin
            eb = qb.pop_front();
            chk("b_seq_rst_n", seq_b, eb.seq);
            chk("b_rst_done", N'(done_b), N'(eb.done));
            chk("b_soft_ack", N'(ack_b), N'(eb.ack));
        end
    end

    initial begin
        ma = '{origin: 0, soft_s: -1, done: 1'b0};
        mb = '{origin: 0, soft_s: -1, done: 1'b0};
        rst = 1'b0;
        req = 1'b0;

        // Power-up then a one-cycle soft request at edge 20
        repeat (5) cyc(1'b0, 1'b0);
        repeat (19) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        repeat (20) cyc(1'b1, 1'b0);

        // Request during release is ignored
        cyc(1'b0, 1'b0);
        repeat (5) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        repeat (10) cyc(1'b1, 1'b0);

        // Reset mid-sequence at edge 9
        cyc(1'b0, 1'b0);
        repeat (8) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        repeat (16) cyc(1'b1, 1'b0);

        // Reset and soft request on the same edge while done
        cyc(1'b0, 1'b1);
        repeat (14) cyc(1'b1, 1'b0);

        // Request held high across re-entry to done
        repeat (20) cyc(1'b1, 1'b1);
        repeat (5) cyc(1'b1, 1'b0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 63) != 0), ($urandom_range(0, 7) == 0));
        end
        repeat (3) cyc(1'b1, 1'b0);

        @(posedge clk);
        #3;
        n_checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_errors++;
            $display("FAIL queue_drain: got %0d/%0d pending expected 0/0", qa.size(), qb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
